// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants for the synchronous FIFO: default word
//                width, depth, occupancy thresholds and the read-mode
//                encodings selected through the FWFT parameter.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  // Default geometry: 8-bit words, 2^4 = 16 entries.
  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDR_WIDTH    = 4;

  // Default status thresholds, in words of occupancy.
  localparam int DEFAULT_AFULL_THRESH  = 12;
  localparam int DEFAULT_AEMPTY_THRESH = 4;

  // Read-mode encodings for the FWFT parameter.
  localparam int FWFT_STANDARD    = 0;  // registered read, one cycle latency
  localparam int FWFT_FALLTHROUGH = 1;  // head word presented combinationally

  // Occupancy after one cycle, given which of write/read were accepted.
  function automatic logic [31:0] next_count(input logic [31:0] cur,
                                             input logic        wr_acc,
                                             input logic        rd_acc);
    logic [31:0] res;
    res = cur;
    if (wr_acc && !rd_acc) begin
      res = cur + 32'd1;
    end else if (rd_acc && !wr_acc) begin
      res = cur - 32'd1;
    end
    return res;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sdp_ram_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_ram_sync
//  Description : Simple dual-port storage array. One synchronous write port,
//                one asynchronous read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sdp_ram_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int C_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];

  // Store the write word on the rising edge; no reset so the array maps to RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is purely combinational from the address.
  assign rdata = mem_q[raddr];

endmodule : sdp_ram_sync
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Single-clock parameterised FIFO controller. Holds the read
//                and write pointers, occupancy count, status flags, error
//                pulses and (in standard mode) the output read register.
//                Storage lives in sdp_ram_sync.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH  = DEFAULT_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH,
  parameter int FWFT          = FWFT_STANDARD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                C_PW       = ADDR_WIDTH + 1;
  localparam logic [C_PW-1:0]   C_DEPTH    = C_PW'(1 << ADDR_WIDTH);
  localparam logic [C_PW-1:0]   C_PTR_ONE  = C_PW'(1);
  localparam logic [C_PW-1:0]   C_AFULL    = C_PW'(AFULL_THRESH);
  localparam logic [C_PW-1:0]   C_AEMPTY   = C_PW'(AEMPTY_THRESH);

  // Pointers carry one extra bit so they wrap naturally over twice the depth.
  logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PW-1:0] count_q,  count_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [31:0]           count_next_wide;

  // Flags decode the registered count only, so they are glitch-free.
  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AFULL);
  assign almost_empty = (count_q <= C_AEMPTY);
  assign count        = count_q;

  // A write into a full FIFO and a read from an empty one are always refused,
  // whatever the other port does that cycle; reset masks both requests.
  assign wr_acc    = wr_en && !full  && !rst;
  assign rd_acc    = rd_en && !empty && !rst;
  assign overflow  = wr_en && full  && !rst;
  assign underflow = rd_en && empty && !rst;

  assign count_next_wide = next_count(32'(count_q), wr_acc, rd_acc);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_next_wide[C_PW-1:0];
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
  end

  // Pointer and occupancy registers; reset returns the FIFO to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sdp_ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
      // Head word is always on the output; rd_en only acknowledges it.
      assign rd_data  = ram_rdata;
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      // Capture the head word on an accepted read; otherwise hold the data.
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_acc) begin
          rd_data_d  = ram_rdata;
          rd_valid_d = 1'b1;
        end
      end

      // Output read register, cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule : sync_fifo_param
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Directed self-checking bench. Instance u_std uses the
//                registered read mode, u_fwft the fall-through mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       wr_en0 = 1'b0, rd_en0 = 1'b0;
  logic [7:0] wr_data0 = 8'h00;
  logic [7:0] rd_data0;
  logic       rd_valid0, full0, afull0, empty0, aempty0, ovf0, unf0;
  logic [4:0] count0;

  logic       wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [7:0] wr_data1 = 8'h00;
  logic [7:0] rd_data1;
  logic       rd_valid1, full1, afull1, empty1, aempty1, ovf1, unf1;
  logic [4:0] count1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .almost_full(afull0),
    .empty(empty0), .almost_empty(aempty0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .almost_full(afull1),
    .empty(empty1), .almost_empty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_empty",    32'(empty0),    32'd1);
    chk("rst_aempty",   32'(aempty0),   32'd1);
    chk("rst_full",     32'(full0),     32'd0);
    chk("rst_afull",    32'(afull0),    32'd0);
    chk("rst_rdvalid",  32'(rd_valid0), 32'd0);
    chk("rst_rddata",   32'(rd_data0),  32'h00);
    chk("rst_count",    32'(count0),    32'd0);
    chk("rst_ovf",      32'(ovf0),      32'd0);
    chk("rst_unf",      32'(unf0),      32'd0);
    chk("rst_fwft_vld", 32'(rd_valid1), 32'd0);

    // ---------------- FWFT: fall-through of a single word ----------------
    wr_en1 = 1'b1; wr_data1 = 8'h5A;
    tick();
    wr_en1 = 1'b0;
    chk("fwft_valid", 32'(rd_valid1), 32'd1);
    chk("fwft_data",  32'(rd_data1),  32'h5A);
    chk("fwft_empty", 32'(empty1),    32'd0);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("fwft_pop_empty", 32'(empty1),    32'd1);
    chk("fwft_pop_valid", 32'(rd_valid1), 32'd0);
    // Two words: head shown first, rd_en advances to the second.
    wr_en1 = 1'b1; wr_data1 = 8'h11;
    tick();
    wr_data1 = 8'h22;
    tick();
    wr_en1 = 1'b0;
    chk("fwft_head1", 32'(rd_data1), 32'h11);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("fwft_head2", 32'(rd_data1), 32'h22);
    chk("fwft_cnt1",  32'(count1),   32'd1);

    // ---------------- standard: fill to full ----------------
    for (int i = 1; i <= 16; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(i);
      tick();
      chk("fill_count", 32'(count0), 32'(i));
      chk("fill_afull", 32'(afull0), (i >= 12) ? 32'd1 : 32'd0);
      chk("fill_full",  32'(full0),  (i == 16) ? 32'd1 : 32'd0);
    end
    wr_data0 = 8'hAA;   // 17th write, still requested
    #1;
    chk("ovf_pulse", 32'(ovf0), 32'd1);
    tick();
    wr_en0 = 1'b0;
    #1;
    chk("ovf_count", 32'(count0), 32'd16);
    chk("ovf_clear", 32'(ovf0),   32'd0);

    // ---------------- standard: drain in order ----------------
    rd_en0 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("drain_valid", 32'(rd_valid0), 32'd1);
      chk("drain_data",  32'(rd_data0),  32'(i));
    end
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("unf_pulse",   32'(unf0),   32'd1);   // rd_en still high while empty
    tick();
    rd_en0 = 1'b0;
    chk("unf_valid", 32'(rd_valid0), 32'd0);
    chk("unf_hold",  32'(rd_data0),  32'h10);

    // ---------------- standard: steady state at count 8 ----------------
    for (int i = 0; i < 8; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(8'h20 + i);
      tick();
    end
    chk("c8_count", 32'(count0), 32'd8);
    rd_en0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data0 = 8'(8'h28 + k);
      tick();
      chk("c8_steady", 32'(count0),   32'd8);
      chk("c8_order",  32'(rd_data0), 32'(8'h20 + k));
      chk("c8_valid",  32'(rd_valid0), 32'd1);
    end
    rd_en0 = 1'b0;
    wr_data0 = 8'h40;
    tick();                      // one more write -> count 9
    chk("c9_count", 32'(count0), 32'd9);

    // ---------------- reset with write pending ----------------
    rst = 1'b1;                  // wr_en0 still 1
    tick();
    rst = 1'b0; wr_en0 = 1'b0;
    #1;
    chk("mrst_count", 32'(count0),    32'd0);
    chk("mrst_empty", 32'(empty0),    32'd1);
    chk("mrst_ovf",   32'(ovf0),      32'd0);
    chk("mrst_unf",   32'(unf0),      32'd0);
    chk("mrst_valid", 32'(rd_valid0), 32'd0);
    chk("mrst_fwft",  32'(count1),    32'd0);

    // ---------------- simultaneous at the boundaries ----------------
    wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 8'h77;
    #1;
    chk("e_both_unf", 32'(unf0), 32'd1);
    tick();
    rd_en0 = 1'b0;
    chk("e_both_count", 32'(count0),    32'd1);
    chk("e_both_valid", 32'(rd_valid0), 32'd0);
    for (int i = 1; i < 16; i++) begin
      wr_data0 = 8'(8'h77 + i);
      tick();
    end
    chk("f_full", 32'(full0), 32'd1);
    wr_data0 = 8'hEE; rd_en0 = 1'b1;
    #1;
    chk("f_both_ovf", 32'(ovf0), 32'd1);
    tick();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    chk("f_both_count", 32'(count0),   32'd15);
    chk("f_both_data",  32'(rd_data0), 32'h77);
    chk("f_both_valid", 32'(rd_valid0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_sync_fifo_param
`default_nettype wire

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, depth = 2^ADDR_WIDTH words (16).
REQ-003 SHALL have parameter AFULL_THRESH, default 12, almost_full asserted when count >= this value.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, almost_empty asserted when count <= this value.
REQ-005 SHALL have parameter FWFT, default 0, 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-010 SHALL have port rd_en  input  1  read request (pop).
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  read word.
REQ-012 SHALL have port rd_valid  output  1  rd_data valid qualifier.
REQ-013 SHALL have ports full, almost_full, empty, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-016 Write accepted iff wr_en=1 and full=0; word stored at wr_ptr, wr_ptr increments next edge.
REQ-017 Read accepted iff rd_en=1 and empty=0; rd_ptr increments next edge.
REQ-018 Pointers ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address RAM; natural wrap from 2^(ADDR_WIDTH+1)-1 to 0.
REQ-019 count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-020 full = (count == 2^ADDR_WIDTH); empty = (count == 0); both decoded from registered count only.
REQ-021 Write while full is rejected even if a read is accepted the same cycle; overflow pulses 1 for that cycle; no state change from the write.
REQ-022 Read while empty is rejected even if a write is accepted the same cycle; underflow pulses 1 for that cycle.
REQ-023 FWFT=0: accepted read at edge N drives rd_data = head word and rd_valid=1 after edge N+1 (1-cycle latency); rd_valid=0 otherwise, rd_data holds last value.
REQ-024 FWFT=1: rd_data = RAM[rd_ptr] combinationally, rd_valid = !empty; word written into empty FIFO appears one cycle after the write edge; rd_en acknowledges and advances to next word.
REQ-025 Simultaneous accepted read and write at any non-boundary count SHALL keep count constant and preserve order.

Reset
REQ-026 rst=1 at a rising edge SHALL clear wr_ptr, rd_ptr, count to 0 regardless of in-flight requests; wr_en/rd_en ignored that cycle.
REQ-027 After reset: empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0 (FWFT=0), overflow=0, underflow=0.
REQ-028 RAM contents SHALL NOT be cleared on reset; no data is readable until re-written.

Structure
REQ-029 Shared package fifo_pkg SHALL hold default width/depth/threshold constants and the FWFT mode encodings.
REQ-030 Storage SHALL be sub-module sdp_ram_sync: one write port (clk, we, waddr, wdata), asynchronous read port (raddr, rdata), no reset.
REQ-031 Controller (pointers, count, flags, read register) SHALL be in sync_fifo_param; no other sub-modules.

Verification (defaults, DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-032 Reset, then write 0x01..0x10 -> full=1 after 16th write, count=16, almost_full=1 from count=12; 17th write 0xAA -> overflow=1 one cycle, count stays 16.
REQ-033 FWFT=0: from full, read 16 -> rd_data 0x01..0x10 in order, each one cycle after rd_en, empty=1 after last; extra rd_en -> underflow=1, rd_valid=0.
REQ-034 Count=8, wr_en=rd_en=1 for 20 cycles -> count stays 8, ptr wrap exercised, output order matches input.
REQ-035 FWFT=1: write 0x5A into empty -> next cycle rd_valid=1, rd_data=0x5A without rd_en; rd_en -> empty=1 next cycle.
REQ-036 Empty, wr_en=rd_en=1 same cycle -> write accepted, underflow=1, count=1; full, wr_en=rd_en=1 -> read accepted, overflow=1, count=15.
REQ-037 rst asserted at count=9 with wr_en=1 -> next cycle count=0, empty=1, all pulses 0.
